// File: rtl/nibble_adder_seq.sv
// Purpose : adds or subtracts two 4*NIBBLES-bit operands one nibble pair per
//           beat (LS nibble first) through a single 4-bit slice with a chained
//           carry flop, assembling the full-width result.
// Latency : out_valid rises on the edge that accepts the last beat; in_ready
//           returns the cycle after the result handshake.
// Backpressure: in_ready is low while a result is held; a held result waits
//           indefinitely for out_ready. Input stalls hold state and carry.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   abort           - synchronous clear of the operation in progress
//   in_valid/ready  - operand beat handshake; in_a/in_b nibbles
//   in_sub, in_cin  - mode and carry-in, sampled on the first beat only
//   out_valid/ready - result handshake; out_sum, out_cout (carry / no-borrow)
//   busy, beat_idx  - partial-load indicator and next nibble index
//
// NIBBLES must be within 2..8 (beat_idx is 3 bits wide).
module nibble_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic                   in_sub,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy,
    output logic [2:0]             beat_idx
);

    localparam int         W    = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t         r_state;
    logic [2:0]     r_beat_idx;
    logic           r_carry;
    logic           r_sub;
    logic [W-1:0]   r_sum;
    logic           r_cout;

    state_t         w_state_nxt;
    logic [2:0]     w_beat_idx_nxt;
    logic           w_carry_nxt;
    logic           w_sub_nxt;
    logic [W-1:0]   w_sum_nxt;
    logic           w_cout_nxt;

    logic           w_first;
    logic           w_sub_eff;
    logic [3:0]     w_b_eff;
    logic           w_c_eff;
    logic [4:0]     w_s;
    logic [W-1:0]   w_sum_ins;

    // Mode and carry-in come straight from the inputs on the first beat so
    // the slice needs no bubble; later beats use the latched mode and the
    // carry flop. Subtraction is A + ~B + 1, so carry-out means "no borrow".
    assign w_first   = (r_beat_idx == 3'd0);
    assign w_sub_eff = w_first ? in_sub : r_sub;
    assign w_b_eff   = w_sub_eff ? ~in_b : in_b;
    assign w_c_eff   = w_first ? (in_sub | in_cin) : r_carry;
    assign w_s       = 5'(in_a) + 5'(w_b_eff) + 5'(w_c_eff);

    // Current sum with the slice result dropped into the addressed nibble.
    always_comb begin
        w_sum_ins = r_sum;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_beat_idx == 3'(i)) begin
                w_sum_ins[4*i +: 4] = w_s[3:0];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_idx_nxt = r_beat_idx;
        w_carry_nxt    = r_carry;
        w_sub_nxt      = r_sub;
        w_sum_nxt      = r_sum;
        w_cout_nxt     = r_cout;

        if (abort) begin
            // Abort wins over any beat or result handshake in the same cycle.
            w_state_nxt    = COLLECT;
            w_beat_idx_nxt = 3'd0;
            w_carry_nxt    = 1'b0;
            w_sub_nxt      = 1'b0;
            w_sum_nxt      = '0;
            w_cout_nxt     = 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        w_sum_nxt = w_sum_ins;
                        if (w_first) begin
                            w_sub_nxt = in_sub;
                        end
                        if (r_beat_idx == LAST) begin
                            w_cout_nxt     = w_s[4];
                            w_carry_nxt    = 1'b0;
                            w_beat_idx_nxt = 3'd0;
                            w_state_nxt    = HOLD;
                        end else begin
                            w_carry_nxt    = w_s[4];
                            w_beat_idx_nxt = r_beat_idx + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = COLLECT;
                    end
                end
                default: begin
                    w_state_nxt = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= COLLECT;
            r_beat_idx <= 3'd0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_idx <= w_beat_idx_nxt;
            r_carry    <= w_carry_nxt;
            r_sub      <= w_sub_nxt;
            r_sum      <= w_sum_nxt;
            r_cout     <= w_cout_nxt;
        end
    end

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == COLLECT) && (r_beat_idx != 3'd0);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign beat_idx  = r_beat_idx;

endmodule

// File: tb/tb_nibble_adder_seq.sv
// Scoreboard bench for nibble_adder_seq: the stimulus process pushes the
// expected {cout, sum} of every complete operation into a queue; a monitor
// pops and compares on each rising out_valid.
module tb_nibble_adder_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           abort = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     in_a = '0;
    logic [3:0]     in_b = '0;
    logic           in_sub = 1'b0;
    logic           in_cin = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic           busy;
    logic [2:0]     beat_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];
    logic       mon_prev = 1'b0;

    nibble_adder_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy), .beat_idx(beat_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-operand reference: plain wide arithmetic, no nibble chaining.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
        longint unsigned x;
        logic [W-1:0]    d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        x = longint'(a) + longint'(b) + longint'(cin);
        return x[W:0];
    endfunction

    // Monitor: one comparison per result presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev <= 1'b0;
        end else begin
            if (out_valid && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h with no result expected", {out_cout, out_sum});
                end else begin
                    chk("result", 32'({out_cout, out_sum}), 32'(exp_q.pop_front()));
                end
            end
            mon_prev <= out_valid;
        end
    end

    task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic c, input logic ab);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_sub = s; in_cin = c; abort = ab;
        @(posedge clk);
    endtask

    // One complete operation. gap = idle cycles before each later beat;
    // scramble = drive random in_sub/in_cin on later beats.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, input int gap, input bit scramble);
        logic s, c;
        exp_q.push_back(model(a, b, sub, cin));
        for (int i = 0; i < NIBBLES; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    chk("busy_gap", 32'(busy), 32'd1);
                end
            end
            s = sub; c = cin;
            if (i > 0 && scramble) begin
                s = 1'($urandom); c = 1'($urandom);
            end
            beat(a[4*i +: 4], b[4*i +: 4], s, c, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(negedge clk);
            chk("ready_after_hs", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, held;
        logic [W:0]   e;

        // 1. reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_beat_idx", 32'(beat_idx), 32'd0);

        // 2. basic add back-to-back
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);

        // 3. overflow and subtract
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h1000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h0001, 16'h0002, 1'b1, 1'b1, 0, 1'b0);

        // 4. backpressure: result held, new beats refused
        out_ready = 1'b0;
        do_op(16'hABCD, 16'h1111, 1'b0, 1'b1, 0, 1'b0);
        e = model(16'hABCD, 16'h1111, 1'b0, 1'b1);
        held = e[W-1:0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 4'($urandom); in_b = 4'($urandom);
            chk("bp_sum_stable", 32'(out_sum), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_beat_idx", 32'(beat_idx), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, 1'b0);

        // 5. mode latch and input stalls
        do_op(16'h5555, 16'h1234, 1'b1, 1'b0, 0, 1'b1);
        do_op(16'h89AB, 16'h7777, 1'b0, 1'b1, 3, 1'b1);

        // randomized operations
        for (int n = 0; n < 30; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            do_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        // 6a. abort after two beats with a carry pending
        beat(4'h8, 4'h8, 1'b0, 1'b0, 1'b0);
        beat(4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_beat_idx", 32'(beat_idx), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(out_sum), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        // 6b. abort coincident with the last beat
        beat(4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
        beat(4'h3, 4'h4, 1'b0, 1'b0, 1'b0);
        beat(4'h5, 4'h6, 1'b0, 1'b0, 1'b0);
        beat(4'h7, 4'h8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_last_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        chk("abort_last_sum", 32'(out_sum), 32'd0);

        // 6c. asynchronous reset in the middle of a beat
        do_op(16'h4321, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
        beat(4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        beat(4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_sum", 32'(out_sum), 32'd0);
        chk("arst_out_cout", 32'(out_cout), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_beat_idx", 32'(beat_idx), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
